// File: rtl/prbs9_tx.sv
// PRBS9 (x^9 + x^5 + 1) transmit source with programmable-rate valid strobe and periodic error injection.
// Latency: with i_rate=R the first o_valid follows the (R+1)th enabled edge; registered outputs, no comb paths.
// Backpressure: none; the downstream checker samples o_bit/o_ref only while o_valid=1, and i_enable=0 freezes the stream.
//
// Ports:
//   clock, i_reset       : system clock, asynchronous active-high reset
//   i_enable             : run enable; low holds LFSR, divider, error phase and counters
//   i_seed_load, i_seed  : single-cycle load of a new LFSR state (0 maps to 9'h1FF)
//   i_rate               : one strobe every i_rate+1 enabled cycles
//   i_err_period         : invert one bit every i_err_period valid bits (0 = off)
//   o_bit, o_ref, o_valid: transmitted bit, clean reference bit, qualifying strobe
//   o_bit_count          : valid bits emitted since reset (wraps at 2^64)
//   o_inj_count          : inverted bits emitted since reset (wraps at 2^64)
module prbs9_tx #(
  parameter int          NB_RATE = 8,
  parameter int          NB_ERR  = 16,
  parameter logic [8:0]  SEED    = 9'h1FF
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_seed_load,
  input  logic [8:0]          i_seed,
  input  logic [NB_RATE-1:0]  i_rate,
  input  logic [NB_ERR-1:0]   i_err_period,
  output logic                o_bit,
  output logic                o_ref,
  output logic                o_valid,
  output logic [63:0]         o_bit_count,
  output logic [63:0]         o_inj_count
);

  logic [8:0]         lfsr_q,    lfsr_d;
  logic [NB_RATE-1:0] div_cnt_q, div_cnt_d;
  logic [NB_ERR-1:0]  err_cnt_q, err_cnt_d;
  logic               valid_q,   valid_d;
  logic               bit_q,     bit_d;
  logic               ref_q,     ref_d;
  logic [63:0]        bit_cnt_q, bit_cnt_d;
  logic [63:0]        inj_cnt_q, inj_cnt_d;

  logic               err_on;
  logic [NB_ERR-1:0]  err_last;
  logic               inj;
  logic               fb;

  assign fb       = lfsr_q[8] ^ lfsr_q[4];
  assign err_on   = (i_err_period != '0);
  assign err_last = i_err_period - NB_ERR'(1);
  // >= rather than == keeps the phase sane if i_err_period is lowered mid-stream.
  assign inj      = err_on && (err_cnt_q >= err_last);

  always_comb begin
    lfsr_d    = lfsr_q;
    div_cnt_d = div_cnt_q;
    err_cnt_d = err_cnt_q;
    valid_d   = 1'b0;
    bit_d     = bit_q;
    ref_d     = ref_q;
    bit_cnt_d = bit_cnt_q;
    inj_cnt_d = inj_cnt_q;

    if (i_seed_load) begin
      // The all-zero state would lock the LFSR, so it is replaced by all ones.
      lfsr_d    = (i_seed == 9'd0) ? 9'h1FF : i_seed;
      div_cnt_d = '0;
      err_cnt_d = '0;
    end else if (i_enable) begin
      // >= so that lowering i_rate below the current count cannot strand the divider.
      if (div_cnt_q >= i_rate) begin
        div_cnt_d = '0;
        valid_d   = 1'b1;
        ref_d     = lfsr_q[8];
        bit_d     = lfsr_q[8] ^ inj;
        lfsr_d    = {lfsr_q[7:0], fb};
        bit_cnt_d = bit_cnt_q + 64'd1;
        if (inj) begin
          err_cnt_d = '0;
          inj_cnt_d = inj_cnt_q + 64'd1;
        end else if (err_on) begin
          err_cnt_d = err_cnt_q + NB_ERR'(1);
        end else begin
          err_cnt_d = '0;
        end
      end else begin
        div_cnt_d = div_cnt_q + NB_RATE'(1);
      end
    end
  end

  always_ff @(posedge clock or posedge i_reset) begin
    if (i_reset) begin
      lfsr_q    <= SEED;
      div_cnt_q <= '0;
      err_cnt_q <= '0;
      valid_q   <= 1'b0;
      bit_q     <= 1'b0;
      ref_q     <= 1'b0;
      bit_cnt_q <= '0;
      inj_cnt_q <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      div_cnt_q <= div_cnt_d;
      err_cnt_q <= err_cnt_d;
      valid_q   <= valid_d;
      bit_q     <= bit_d;
      ref_q     <= ref_d;
      bit_cnt_q <= bit_cnt_d;
      inj_cnt_q <= inj_cnt_d;
    end
  end

  assign o_valid     = valid_q;
  assign o_bit       = bit_q;
  assign o_ref       = ref_q;
  assign o_bit_count = bit_cnt_q;
  assign o_inj_count = inj_cnt_q;

endmodule

// File: doc/prbs9_tx.md
Name: prbs9_tx

Overview:
PRBS9 (x^9 + x^5 + 1) transmit-side source for the link test path. It produces the bit stream that the downstream BER checker compares against its own reference copy.
- Provides a programmable-rate valid strobe.
- Provides a clean reference bit and a transmitted bit with optional periodic error injection.
- Keeps running bit and injected-error counters for cross-checking against the BER counts.

Parameters:
NB_RATE, 8, width of rate-divider input
NB_ERR, 16, width of error-injection period input
SEED, 9'h1FF, LFSR value after reset

Ports:
clock  input  1  system clock
i_reset  input  1  asynchronous, active-high reset
i_enable  input  1  run enable; low freezes all sequential state except counters already updated
i_seed_load  input  1  single-cycle synchronous pulse, loads i_seed
i_seed  input  9  LFSR load value; 0 is replaced by 9'h1FF
i_rate  input  NB_RATE  strobe divider: one valid every i_rate+1 enabled cycles
i_err_period  input  NB_ERR  inject one inverted bit every i_err_period valid bits; 0 = off
o_bit  output  1  transmitted bit (may be inverted)
o_ref  output  1  clean PRBS bit
o_valid  output  1  one-cycle strobe qualifying o_bit/o_ref
o_bit_count  output  64  number of valid bits emitted
o_inj_count  output  64  number of inverted bits emitted

Behaviour:
- Async reset (immediate, no clock edge needed):
  - lfsr=SEED, div_cnt=0, err_cnt=0.
  - o_valid=0, o_bit=0, o_ref=0.
  - o_bit_count=0, o_inj_count=0.
- LFSR:
  - fb = lfsr[8]^lfsr[4]; next = {lfsr[7:0], fb}; output bit = lfsr[8].
  - Period is 511 bits.
  - From 9'h1FF, the first 16 bits are 1111111110000011.
- Priority each rising edge: i_seed_load > i_enable > idle.
- Seed load:
  - lfsr <= (i_seed==0) ? 9'h1FF : i_seed.
  - div_cnt<=0, err_cnt<=0, o_valid<=0.
  - Counts, o_bit and o_ref are unchanged.
- Enabled, no load:
  - If div_cnt >= i_rate (uses >= so a lowered i_rate takes effect without lockup): strobe cycle, div_cnt<=0.
  - Otherwise div_cnt<=div_cnt+1 and o_valid<=0.
- Strobe cycle:
  - o_valid<=1, o_ref<=lfsr[8], o_bit<=lfsr[8]^inj, lfsr advances, o_bit_count+1.
  - inj = (i_err_period!=0) && (err_cnt >= i_err_period-1).
  - If inj: err_cnt<=0 and o_inj_count+1. Else if i_err_period!=0: err_cnt+1. Else err_cnt held at 0.
- Latency:
  - i_rate=0: o_valid rises on the edge where i_enable is first sampled high, then stays high every cycle.
  - i_rate=R: first o_valid on the (R+1)th enabled edge, then every R+1 enabled cycles.
- Disabled (i_enable=0, no load):
  - o_valid<=0.
  - lfsr, div_cnt, err_cnt and all counts hold.
  - o_bit/o_ref hold their last values.
- Injection pattern: with period P, inverted bits are valid-bit indices P-1, 2P-1, ... counted from reset or the last seed load.
  - P=1 inverts every bit.
- o_bit/o_ref are stable between strobes; the consumer samples only when o_valid=1.
- 64-bit counters wrap modulo 2^64.
- Simultaneous load and enable: the load wins and no strobe is issued that cycle.
- Reset mid-stream: outputs go to reset values at once. After release, the stream restarts from SEED.

Test Plan:
1. Reset, i_rate=0, i_err_period=0, enable -> o_valid high every cycle; first 16 o_bit = 1111111110000011 = o_ref; bits 511..526 repeat bits 0..15; o_bit_count=527, o_inj_count=0.
2. i_rate=3 -> o_valid on every 4th enabled cycle (first on 4th edge); o_bit/o_ref constant between strobes; 40 cycles give o_bit_count=10.
3. i_err_period=4, 100 strobes -> o_bit != o_ref exactly at indices 3,7,...,99; o_inj_count=25; i_err_period=1 -> o_bit = ~o_ref on every strobe.
4. Seed load of 9'h001 -> first 9 bits 000000001. Seed load of 0 -> stream identical to the post-reset stream. A load pulse together with i_enable -> no o_valid that cycle; err_cnt phase restarts.
5. Deassert i_enable for 7 cycles mid-stream -> o_valid=0, then the sequence continues with no skipped or repeated bit and counts unchanged during the gap.
6. Assert i_reset between clock edges mid-stream -> o_valid, o_bit, o_ref and both counts read 0 before the next edge; after release the stream restarts with 111111111.
